// File: rtl/hart_run_ctrl_pkg.sv
// Shared encodings for the hart run/debug controller: FSM states, stop causes
// and the default enabled-cycle budget.
package hart_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSED = 3'd3,
    ST_STEP   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_HALT    = 3'd1,
    CAUSE_TRAP    = 3'd2,
    CAUSE_BREAK   = 3'd3,
    CAUSE_STOP    = 3'd4,
    CAUSE_TIMEOUT = 3'd5
  } cause_e;

  localparam int unsigned DEF_MAX_CYCLES = 32'd100000;

endpackage

// File: rtl/hart_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; o_cnt_next exposes the value
// the counter takes at the next edge.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic [W-1:0] o_cnt_next
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt      = cnt_q;
  assign o_cnt_next = cnt_d;

endmodule

// File: rtl/hart_run_ctrl.sv
// Run/debug sequencer for the single-cycle hart: reset, clock-enable, counters
// and stop causes. Define HART_RUN_CTRL_BP_EN to build the PC breakpoint compare.
//
// state  | meaning
// IDLE   | hart held in reset, waiting for start
// RESET  | hart reset asserted for RST_CYCLES cycles
// RUN    | hart enabled every cycle
// PAUSED | hart stalled, state inspectable, resume or step
// STEP   | hart enabled for one cycle, then back to PAUSED
// DONE   | run finished (halt/trap/timeout), hart stalled out of reset
module hart_run_ctrl
  import hart_run_ctrl_pkg::*;
#(
  parameter int          CNT_W      = 32,
  parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int          RST_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_step,
  input  logic             i_stop,
  input  logic             i_bp_en,
  input  logic [31:0]      i_bp_addr,
  input  logic             i_retire_valid,
  input  logic             i_retire_halt,
  input  logic             i_retire_trap,
  input  logic [31:0]      i_retire_pc,
  output logic             o_hart_rst,
  output logic             o_hart_en,
  output logic [2:0]       o_state,
  output logic             o_done,
  output logic [2:0]       o_cause,
  output logic [CNT_W-1:0] o_cycles,
  output logic [CNT_W-1:0] o_instret
);

  localparam int            RW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYCLES - 1);

  state_e          state_q, state_d;
  cause_e          cause_q, cause_d;
  logic [RW-1:0]   rcnt_q, rcnt_d;
  logic            hart_rst_q, hart_rst_d;
  logic            hart_en_q, hart_en_d;
  logic            done_q, done_d;

  logic            cnt_clr;
  logic            enabled;
  logic            ev_trap, ev_halt, ev_timeout, ev_break;
  logic [CNT_W-1:0] cycles, cycles_next;
  logic [CNT_W-1:0] instret, unused_instret_next;

  assign enabled    = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign ev_trap    = i_retire_valid & i_retire_trap;
  assign ev_halt    = i_retire_valid & i_retire_halt;
  // Compare against the post-increment count so the budget is exact.
  assign ev_timeout = (MAX_CYCLES != 0) && (cycles_next == CNT_W'(MAX_CYCLES));

`ifdef HART_RUN_CTRL_BP_EN
  assign ev_break = i_bp_en & i_retire_valid & (i_retire_pc == i_bp_addr);
`else
  logic unused_bp;
  assign ev_break  = 1'b0;
  assign unused_bp = ^{i_bp_en, i_bp_addr, i_retire_pc};
`endif

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    rcnt_d  = rcnt_q;
    cnt_clr = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_d = ST_RESET;
          rcnt_d  = RST_LOAD;
          cause_d = CAUSE_NONE;
          cnt_clr = 1'b1;
        end
      end
      ST_RESET: begin
        if (rcnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          rcnt_d = rcnt_q - RW'(1);
        end
      end
      ST_RUN, ST_STEP: begin
        if (state_q == ST_STEP) state_d = ST_PAUSED;
        if (ev_trap) begin
          state_d = ST_DONE;
          cause_d = CAUSE_TRAP;
        end else if (ev_halt) begin
          state_d = ST_DONE;
          cause_d = CAUSE_HALT;
        end else if (ev_timeout) begin
          state_d = ST_DONE;
          cause_d = CAUSE_TIMEOUT;
        end else if (ev_break) begin
          state_d = ST_PAUSED;
          cause_d = CAUSE_BREAK;
        end else if (i_stop) begin
          state_d = ST_PAUSED;
          cause_d = CAUSE_STOP;
        end
      end
      ST_PAUSED: begin
        if (i_start) begin
          state_d = ST_RUN;
          cause_d = CAUSE_NONE;
        end else if (i_step) begin
          state_d = ST_STEP;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    hart_rst_d = (state_d == ST_IDLE) || (state_d == ST_RESET);
    hart_en_d  = (state_d == ST_RUN) || (state_d == ST_STEP);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cause_q    <= CAUSE_NONE;
      rcnt_q     <= '0;
      hart_rst_q <= 1'b1;
      hart_en_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      rcnt_q     <= rcnt_d;
      hart_rst_q <= hart_rst_d;
      hart_en_q  <= hart_en_d;
      done_q     <= done_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycles (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (cnt_clr),
    .i_inc      (enabled),
    .o_cnt      (cycles),
    .o_cnt_next (cycles_next)
  );

  sat_counter #(.W(CNT_W)) u_instret (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (cnt_clr),
    .i_inc      (enabled & i_retire_valid),
    .o_cnt      (instret),
    .o_cnt_next (unused_instret_next)
  );

  assign o_hart_rst = hart_rst_q;
  assign o_hart_en  = hart_en_q;
  assign o_state    = state_q;
  assign o_done     = done_q;
  assign o_cause    = cause_q;
  assign o_cycles   = cycles;
  assign o_instret  = instret;

endmodule

// File: doc/hart_run_ctrl.md
Name: hart_run_ctrl

Overview:
- Run/debug controller that sequences the single-cycle hart.
- Generates the hart's reset and a clock-enable (stall), so the hart updates PC, register file and dmem writes only while o_hart_en=1.
- Counts cycles and retired instructions, and stops on halt, trap, PC breakpoint, external stop or timeout.
- Sits between the bench or debug host and the hart's retire interface.

Parameters:
- CNT_W, 32, width of cycle and instret counters.
- MAX_CYCLES, 32'd100000, enabled-cycle budget per run; 0 disables the timeout.
- RST_CYCLES, 2, number of cycles o_hart_rst is held in the RESET state (must be ≥1).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_start  in  1  pulse: IDLE/DONE→reset+run; PAUSED→resume.
- i_step  in  1  pulse: PAUSED→execute exactly one instruction.
- i_stop  in  1  pulse: RUN→PAUSED.
- i_bp_en  in  1  breakpoint enable.
- i_bp_addr  in  32  breakpoint PC.
- i_retire_valid  in  1  hart retire valid.
- i_retire_halt  in  1  hart retire halt.
- i_retire_trap  in  1  hart retire trap.
- i_retire_pc  in  32  hart retire PC.
- o_hart_rst  out  1  reset to hart.
- o_hart_en  out  1  hart state-update enable.
- o_state  out  3  current FSM state.
- o_done  out  1  run finished (DONE state).
- o_cause  out  3  NONE=0, HALT=1, TRAP=2, BREAK=3, STOP=4, TIMEOUT=5.
- o_cycles  out  CNT_W  enabled cycles since last start.
- o_instret  out  CNT_W  retired instructions since last start.

Behaviour:
- All outputs are registered. Reset values:
  - state=IDLE, o_hart_rst=1, o_hart_en=0, o_done=0, o_cause=NONE, counters=0.
  - i_rst mid-operation returns to these values on the next edge regardless of state.
- States: IDLE=0, RESET=1, RUN=2, PAUSED=3, STEP=4, DONE=5.
- IDLE:
  - hart_rst=1, hart_en=0.
  - i_start → RESET; counters cleared; cause←NONE.
- RESET:
  - hart_rst=1 for exactly RST_CYCLES cycles (down-counter), then → RUN.
  - i_start/i_step/i_stop are ignored.
- RUN:
  - hart_rst=0, hart_en=1.
  - Each cycle: cycles+=1; instret+=1 if i_retire_valid.
  - Retire inputs are sampled at the posedge ending an enabled cycle.
- Termination events, evaluated in RUN and STEP, in priority order:
  1. trap (valid&trap) → DONE, cause TRAP.
  2. halt (valid&halt) → DONE, cause HALT.
  3. timeout (MAX_CYCLES≠0 and post-increment cycles==MAX_CYCLES) → DONE, cause TIMEOUT.
  4. breakpoint (i_bp_en & valid & pc==i_bp_addr) → PAUSED, cause BREAK.
  5. i_stop → PAUSED, cause STOP.
- The terminating instruction itself retires and is counted. o_hart_en drops in the following cycle, so there is zero extra enabled cycles.
- PAUSED:
  - hart_en=0; counters frozen.
  - i_start → RUN and cause←NONE. Breakpoint is break-after, so resuming never re-hits the same retire.
  - i_step → STEP. i_start wins if both are asserted.
- STEP:
  - hart_en=1 for exactly one cycle, counted as in RUN.
  - Then → PAUSED, cause unchanged, unless a trap/halt/timeout event moves to DONE.
  - A breakpoint hit in STEP sets cause BREAK.
- DONE:
  - hart_en=0, hart_rst=0 so hart state remains inspectable; o_done=1.
  - i_start → RESET (fresh run, counters cleared).
- Counters saturate at all-ones and never wrap.
- Pulses on inputs not named for the current state are ignored.

Optional Feature:
- HART_RUN_CTRL_BP_EN defined: breakpoint compare logic is present as described.
- Undefined: i_bp_en and i_bp_addr are still present but ignored, and cause BREAK is never produced. This saves the 32-bit comparator.

Decomposition:
- Package hart_run_ctrl_pkg holds:
  - state encoding constants (IDLE..DONE);
  - cause encoding constants (NONE..TIMEOUT);
  - the default MAX_CYCLES.
- Sub-module sat_counter (width CNT_W; inputs clr, inc; saturating output) is instantiated twice, for cycles and instret. The FSM stays in hart_run_ctrl.

Test Plan:
- Reset, i_start; hart retires 5 instructions, the 5th with halt → hart_rst high for 2 cycles; then DONE, cause=1, cycles=5, instret=5, hart_en=0 the cycle after the halt retire.
- i_bp_en=1, i_bp_addr=0x10, straight-line code → PAUSED after retire at PC 0x10, cause=3, instret=5; one i_step → exactly one enabled cycle, instret=6; i_start → runs on to halt.
- MAX_CYCLES=8, infinite loop (jal x0,0) → DONE at cycles=8, cause=5; a further i_start restarts with counters=0.
- Trap and breakpoint on the same retire at PC 0x8 → cause=2 (trap beats break), state DONE.
- i_stop in cycle 3 of RUN → PAUSED, cause=4, cycles=3; i_stop/i_step during RESET → ignored.
- i_rst asserted mid-RUN at cycles=20 → next edge: IDLE, hart_rst=1, hart_en=0, counters=0, cause=0.
